// File: rtl/act_fetch_engine.sv
// Activation buffer read engine: walks a strided address sequence on port B and
// streams the returned vectors through a small FIFO with valid/ready backpressure.
module act_fetch_engine #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH-1:0] i_stride,
   input  logic [LEN_WIDTH-1:0]  i_length,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [ADDR_WIDTH-1:0] o_buf_addr,
   input  logic [DATA_WIDTH-1:0] i_buf_rdata,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_last
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr_q;
   logic [ADDR_WIDTH-1:0] r_stride;
   logic [ADDR_WIDTH-1:0] r_buf_addr;
   logic [LEN_WIDTH-1:0]  r_length;
   logic [LEN_WIDTH-1:0]  r_issue_cnt;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic                  r_busy;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_last_tag;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [PW:0]           r_count;

   logic                  w_issue;
   logic                  w_last_issue;
   logic                  w_pop;
   logic [PW:0]           w_occ;

   // Slots already promised to an in-flight read count as occupied.
   assign w_occ        = r_count + {{PW{1'b0}}, r_inflight};
   assign w_issue      = (r_state == S_FETCH) && (w_occ < DEPTH_C);
   assign w_last_issue = (r_issue_cnt == (r_length - 1'b1));
   assign w_pop        = o_out_valid && i_out_ready;

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_buf_addr  = w_issue ? r_addr_q : r_buf_addr;
   assign o_out_valid = (r_count != '0);
   assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;
   assign o_out_last  = o_out_valid && r_last_tag[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (r_inflight) begin
         r_mem[r_wr_ptr] <= i_buf_rdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= S_IDLE;
         r_addr_q        <= '0;
         r_stride        <= '0;
         r_buf_addr      <= '0;
         r_length        <= '0;
         r_issue_cnt     <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_last_tag      <= '0;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
      end else begin
         r_done          <= 1'b0;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && w_last_issue;

         if (w_issue) begin
            r_buf_addr  <= r_addr_q;
            r_addr_q    <= r_addr_q + r_stride;
            r_issue_cnt <= r_issue_cnt + 1'b1;
         end

         if (r_inflight) begin
            r_last_tag[r_wr_ptr] <= r_inflight_last;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({r_inflight, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_addr_q    <= i_base_addr;
                  r_stride    <= i_stride;
                  r_length    <= i_length;
                  r_issue_cnt <= '0;
                  if (i_length == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (w_issue && w_last_issue) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // The last-tagged pop leaves the FIFO empty with no read in flight.
               if (w_pop && o_out_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_act_fetch_engine.sv
// Scoreboard bench for act_fetch_engine: the expected stream is computed from
// base + k*stride and checked by a monitor decoupled from the stimulus.
module tb_act_fetch_engine;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [15:0]  base_addr = '0;
   logic [15:0]  stride = '0;
   logic [15:0]  length = '0;
   logic         busy;
   logic         done;
   logic [15:0]  buf_addr;
   logic [127:0] buf_rdata = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         out_last;

   typedef struct packed {
      logic [127:0] d;
      logic         l;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails = 0;
   int   done_seen = 0;
   int   exp_dones = 0;
   bit   rnd_ready = 1'b0;

   act_fetch_engine #(
      .DATA_WIDTH(128),
      .ADDR_WIDTH(16),
      .LEN_WIDTH(16),
      .FIFO_DEPTH(4)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_base_addr(base_addr),
      .i_stride   (stride),
      .i_length   (length),
      .o_busy     (busy),
      .o_done     (done),
      .o_buf_addr (buf_addr),
      .i_buf_rdata(buf_rdata),
      .o_out_valid(out_valid),
      .i_out_ready(out_ready),
      .o_out_data (out_data),
      .o_out_last (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] vec(input logic [15:0] a);
      return {~a, a ^ 16'h5A5A, 16'hC0DE, a, a, a, a, a};
   endfunction

   // Buffer port B: registered read, one cycle of latency.
   always @(posedge clk) buf_rdata <= vec(buf_addr);

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake, checks stall stability.
   logic         prev_stall = 1'b0;
   logic [127:0] prev_data = '0;
   logic         prev_last = 1'b0;
   logic         prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", {127'd0, out_valid}, 128'd1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", {127'd0, out_last}, {127'd0, prev_last});
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_vec: got %0h expected none", out_data);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_last", {127'd0, out_last}, {127'd0, e.l});
            end
         end
         if (done) begin
            chk("done_width", {127'd0, prev_done}, 128'd0);
            done_seen++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         prev_done  = done;
      end
   end

   // Cycle n counts rising edges after the one that sampled start.
   task automatic run_cmd(input logic [15:0] b, input logic [15:0] s, input logic [15:0] l,
                          input int abort_at, input bit mid, output int dcyc, output int fv);
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = b; stride = s; length = l;
      for (int k = 0; k < int'(l); k++) begin
         exp_t e;
         e.d = vec(b + 16'(k) * s);
         e.l = (k == int'(l) - 1);
         q.push_back(e);
      end
      if (abort_at == 0) exp_dones++;
      @(posedge clk);
      #1;
      start = 1'b0;
      base_addr = 16'($urandom); stride = 16'($urandom); length = 16'($urandom);
      dcyc = -1;
      fv = -1;
      for (int n = 1; n <= 3000; n++) begin
         if (mid && n == 4) begin
            start = 1'b1; base_addr = ~b; stride = s + 16'd5; length = l + 16'd2;
         end
         if (mid && n == 5) start = 1'b0;
         if (abort_at != 0 && n == abort_at) rst = 1'b1;
         if (abort_at != 0 && n == abort_at + 1) rst = 1'b0;
         @(negedge clk);
         if (abort_at != 0 && n > abort_at) begin
            if (n == abort_at + 1)
               chk("abort_outs", {busy, done, out_valid, out_last, buf_addr, out_data},
                   '0);
            else
               chk("abort_nodone", {127'd0, done}, 128'd0);
            if (n == abort_at + 6) return;
         end else begin
            if (fv < 0 && out_valid) fv = n;
            if (done) begin
               dcyc = n;
               chk("busy_at_done", {127'd0, busy}, 128'd0);
               return;
            end
            if (l != 0) chk("busy_high", {127'd0, busy}, 128'd1);
         end
         if (n < 3000) begin
            @(posedge clk);
            #1;
         end
      end
      checks++;
      fails++;
      $display("FAIL done_timeout: got none expected done pulse");
   endtask

   initial begin
      int dc;
      int fv;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outs", {busy, done, out_valid, out_last, buf_addr, out_data}, '0);

      run_cmd(16'h0010, 16'd1, 16'd4, 0, 1'b0, dc, fv);
      chk("basic_done_cyc", 128'(dc), 128'd7);
      chk("basic_first_valid", 128'(fv), 128'd3);

      run_cmd(16'hFFFE, 16'd3, 16'd3, 0, 1'b0, dc, fv);
      chk("wrap_done_cyc", 128'(dc), 128'd6);

      rnd_ready = 1'b1;
      run_cmd(16'h0100, 16'd2, 16'd10, 0, 1'b0, dc, fv);
      chk("bp_done_seen", 128'(dc > 0), 128'd1);
      rnd_ready = 1'b0;

      run_cmd(16'h1234, 16'd1, 16'd0, 0, 1'b0, dc, fv);
      chk("zero_done_cyc", 128'(dc), 128'd1);
      chk("zero_no_valid", 128'(fv), 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);

      run_cmd(16'h0400, 16'd4, 16'd6, 0, 1'b1, dc, fv);
      chk("midstart_done_cyc", 128'(dc), 128'd9);

      run_cmd(16'h0800, 16'd1, 16'd8, 5, 1'b0, dc, fv);
      run_cmd(16'h0200, 16'd7, 16'd2, 0, 1'b0, dc, fv);
      chk("post_abort_done_cyc", 128'(dc), 128'd5);

      run_cmd(16'h0300, 16'd1, 16'd3, 0, 1'b0, dc, fv);
      chk("b2b_first_done", 128'(dc), 128'd6);
      run_cmd(16'h0310, 16'd1, 16'd3, 0, 1'b0, dc, fv);
      chk("b2b_second_done", 128'(dc), 128'd6);

      rnd_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         run_cmd(16'($urandom), 16'($urandom), 16'($urandom_range(0, 12)), 0, 1'b0, dc, fv);
         chk("rand_done_seen", 128'(dc > 0), 128'd1);
      end
      rnd_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("queue_empty", 128'(q.size()), 128'd0);
      chk("done_count", 128'(done_seen), 128'(exp_dones));
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/act_fetch_engine.md
# act_fetch_engine

Read-side streaming engine for the activation buffer. On a start command it walks a strided address sequence on the buffer's read port (port B), absorbs the buffer's fixed 1-cycle registered-read latency, and delivers 128-bit activation vectors to the PE array over a valid/ready stream with full backpressure support. It sits between the controller's command path and the activation buffer's read port, and is the consumer counterpart of the loader that fills port A.

## Interface
- DATA_WIDTH, 128: vector width (16 × 8-bit activations).
- ADDR_WIDTH, 16: buffer address width.
- LEN_WIDTH, 16: width of the transfer length field.
- FIFO_DEPTH, 4: output FIFO entries; a power of two, minimum 2.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first buffer address.
- stride  in  ADDR_WIDTH  address increment between vectors.
- length  in  LEN_WIDTH  number of vectors to fetch.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle pulse when a command completes.
- buf_addr  out  ADDR_WIDTH  drives the buffer's port-B address.
- buf_rdata  in  DATA_WIDTH  buffer port-B read data, valid 1 cycle after the address.
- out_valid  out  1  stream data valid.
- out_ready  in  1  PE array ready.
- out_data  out  DATA_WIDTH  activation vector.
- out_last  out  1  marks the final vector of the command.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE + start:
  - latch base_addr, stride, length;
  - if length==0, go to DONE;
  - otherwise go to FETCH with addr_q=base_addr, issue_cnt=0.
- FETCH issue rule: a read issues in a cycle when `occupancy + inflight < FIFO_DEPTH`.
  - occupancy is the registered FIFO count.
  - inflight is a 1-bit flag: a read was issued in the previous cycle.
- On issue:
  - buf_addr = addr_q;
  - next cycle: addr_q += stride, modulo 2^ADDR_WIDTH (wrap, no error);
  - issue_cnt increments.
- A cycle with inflight set writes buf_rdata into the FIFO tail. The tag bit last = (this was issue number length-1) is stored with the entry.
- Read is ignored when no issue is pending. The buffer reads every cycle; inflight is tracked internally.
- When issue_cnt reaches length, go to DRAIN.
- DRAIN: no new issues. When the FIFO is empty, inflight is clear, and the last handshake has occurred, go to DONE.
- DONE: assert done for 1 cycle, then go to IDLE.
- Output handshake: a transfer occurs when out_valid && out_ready.
  - out_data, out_last come from the FIFO head.
  - out_data/out_last are held stable while out_valid && !out_ready.
- start while not in IDLE is ignored; the latched parameters do not change.
- buf_addr is held at its last value when not issuing.
- FIFO write and pop in the same cycle: occupancy is unchanged. The FIFO never overflows; the issue rule guarantees this.
- Read-after-write ordering against the loader is the controller's responsibility; this block does not check it.

## Timing
- Reset values:
  - state=IDLE;
  - busy=0, done=0, out_valid=0, out_last=0;
  - buf_addr=0, out_data=0;
  - FIFO empty, inflight=0.
- rst mid-command aborts immediately. The next cycle is IDLE with an empty FIFO; in-flight read data is discarded. No done pulse is produced.
- start sampled in cycle 0 → first read issued in cycle 1 (buf_addr=base_addr) → buf_rdata valid in cycle 2 → written to FIFO at the end of cycle 2 → out_valid high in cycle 3.
- With out_ready held high, throughput is 1 vector/cycle. A length-N command has its last handshake in cycle N+2.
- busy rises in cycle 1 and stays high through the cycle before done. done pulses the cycle after the last handshake, and busy is low in that cycle.
- length==0: busy never rises; done pulses in cycle 1.
- A new start is accepted in the cycle after done, i.e. back-to-back commands have a 1-cycle gap.
- Backpressure: after out_ready falls, at most FIFO_DEPTH vectors are buffered before issuing stops. Issuing resumes the cycle after occupancy drops.

## Test plan
- Basic stream: base=0x0010, stride=1, length=4, buffer preloaded so mem[a]=a, out_ready=1.
  - Expected: out_data = 0x10,0x11,0x12,0x13 in cycles 3–6;
  - out_last only on 0x13; done in cycle 7.
- Stride and wrap: base=0xFFFE, stride=3, length=3.
  - Expected: buf_addr sequence 0xFFFE, 0x0001, 0x0004;
  - data order matches.
- Backpressure: length=10, out_ready toggled at random (≥30% low).
  - Expected: all 10 vectors delivered in order, none duplicated or lost;
  - out_data stable while stalled;
  - occupancy never exceeds FIFO_DEPTH.
- Zero length and ignored start: length=0 gives done in cycle 1 with no out_valid. A start pulsed mid-command with different parameters does not alter the running stream.
- Reset mid-operation: rst asserted in cycle 5 of a length=8 command.
  - Expected: all outputs at reset values next cycle, no done;
  - a following length=2 command runs correctly from its own base.
- Back-to-back: two length=3 commands with start asserted the cycle after the first done.
  - Expected: 6 vectors total;
  - out_last asserted twice; two done pulses.
